// File: rtl/seq101_scheduler_if.sv
// Bundle between the two word producers and the shared "101" detector scheduler.
// The master side is the requester/observer, and the slave side is the scheduler.
interface seq101_scheduler_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
);
    logic             req_a;
    logic [WIDTH-1:0] data_a;
    logic             ack_a;
    logic             req_b;
    logic [WIDTH-1:0] data_b;
    logic             ack_b;
    logic             busy;
    logic             bit_out;
    logic             det_out;
    logic             done;
    logic             done_id;
    logic [CNT_W-1:0] match_count;
    logic [1:0]       dbg_state;

    // Handshake: a requester holds req and data stable until its one-cycle ack.
    // A req still high during the ack cycle counts as a fresh request.
    modport master (
        output req_a, data_a, req_b, data_b,
        input  ack_a, ack_b, busy, bit_out, det_out, done, done_id, match_count, dbg_state
    );

    modport slave (
        input  req_a, data_a, req_b, data_b,
        output ack_a, ack_b, busy, bit_out, det_out, done, done_id, match_count, dbg_state
    );
endinterface

// File: rtl/seq101_scheduler.sv
// Round-robin shares one overlapping "101" Moore detector between requesters A and B.
// Each accepted word is shifted in MSB-first, and the match count is returned with a done pulse.
module seq101_scheduler #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input logic              clk,
    input logic              rst,
    seq101_scheduler_if.slave bus
);
    localparam int BCW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BCW-1:0]   LAST_BIT = BCW'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_e;
    typedef enum logic [1:0] {D0, D1, D10, D101} det_e;

    state_e           state_q, state_d;
    det_e             det_q, det_d, det_step;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_step;
    logic [CNT_W-1:0] mcount_q, mcount_d;
    logic             last_grant_q, last_grant_d;  // 0 = A, 1 = B
    logic             cur_id_q, cur_id_d;
    logic             done_id_q, done_id_d;
    logic             ack_a_q, ack_a_d;
    logic             ack_b_q, ack_b_d;
    logic             grant_b;
    logic             serial_bit;

    assign serial_bit = shift_q[WIDTH-1];
    // With both requesting, B wins only if A was served last.
    assign grant_b = bus.req_b & (~bus.req_a | ~last_grant_q);

    always_comb begin
        det_step = D0;
        case (det_q)
            D0:      det_step = serial_bit ? D1   : D0;
            D1:      det_step = serial_bit ? D1   : D10;
            D10:     det_step = serial_bit ? D101 : D0;
            D101:    det_step = serial_bit ? D1   : D10;
            default: det_step = D0;
        endcase
    end

    assign cnt_step = (det_step == D101 && cnt_q != CNT_MAX) ? cnt_q + 1'b1 : cnt_q;

    always_comb begin
        state_d      = state_q;
        det_d        = det_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        cnt_d        = cnt_q;
        mcount_d     = mcount_q;
        last_grant_d = last_grant_q;
        cur_id_d     = cur_id_q;
        done_id_d    = done_id_q;
        ack_a_d      = 1'b0;
        ack_b_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.req_a | bus.req_b) begin
                    shift_d      = grant_b ? bus.data_b : bus.data_a;
                    last_grant_d = grant_b;
                    cur_id_d     = grant_b;
                    cnt_d        = '0;
                    det_d        = D0;
                    bit_cnt_d    = '0;
                    ack_a_d      = ~grant_b;
                    ack_b_d      = grant_b;
                    state_d      = S_SHIFT;
                end
            end
            S_SHIFT: begin
                det_d     = det_step;
                shift_d   = {shift_q[WIDTH-2:0], 1'b0};
                bit_cnt_d = bit_cnt_q + 1'b1;
                cnt_d     = cnt_step;
                if (bit_cnt_q == LAST_BIT) begin
                    // Park the detector so no match leaks into DONE or the next word.
                    det_d     = D0;
                    mcount_d  = cnt_step;
                    done_id_d = cur_id_q;
                    state_d   = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            det_q        <= D0;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            cnt_q        <= '0;
            mcount_q     <= '0;
            last_grant_q <= 1'b1;
            cur_id_q     <= 1'b0;
            done_id_q    <= 1'b0;
            ack_a_q      <= 1'b0;
            ack_b_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            det_q        <= det_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            cnt_q        <= cnt_d;
            mcount_q     <= mcount_d;
            last_grant_q <= last_grant_d;
            cur_id_q     <= cur_id_d;
            done_id_q    <= done_id_d;
            ack_a_q      <= ack_a_d;
            ack_b_q      <= ack_b_d;
        end
    end

    assign bus.ack_a       = ack_a_q;
    assign bus.ack_b       = ack_b_q;
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.bit_out     = (state_q == S_SHIFT) & serial_bit;
    assign bus.det_out     = (det_q == D101);
    assign bus.done        = (state_q == S_DONE);
    assign bus.done_id     = done_id_q;
    assign bus.match_count = mcount_q;
    assign bus.dbg_state   = state_q;
endmodule
